// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_N_DEFAULT = 8;

endpackage

// File: rtl/div_step.sv
// Purely combinational single restoring iteration: shift in Q's top bit, trial-subtract divisor.
// No latency, no flow control; the caller decides when to register the result.
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic [N-1:0] i_r,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_r,
    output logic [N-1:0] o_q
);

    // The stored partial remainder is always below the divisor, so only the
    // shifted intermediate needs the extra (N+1)th bit.
    logic [N:0] w_sh;
    logic [N:0] w_dv;
    logic       w_ge;

    assign w_sh = {i_r, i_q[N-1]};
    assign w_dv = {1'b0, i_divisor};
    assign w_ge = (w_sh >= w_dv);

    assign o_r = w_ge ? N'(w_sh - w_dv) : w_sh[N-1:0];
    assign o_q = {i_q[N-2:0], w_ge};

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock; optional DIV_SIGNED_EN adds two's complement fix-up.
// Latency N+1 cycles to finish (1 for divide-by-zero); start is ignored while busy, never queued.
module restoring_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         finish,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(N + 1);

    div_state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]     r_rem, w_rem_nxt;
    logic [N-1:0]     r_q, w_q_nxt;
    logic [N-1:0]     r_dvsr, w_dvsr_nxt;
    logic [N-1:0]     r_quot, w_quot_nxt;
    logic [N-1:0]     r_remo, w_remo_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_fin, w_fin_nxt;
    logic             r_dbz, w_dbz_nxt;

    logic [N-1:0]     w_step_r, w_step_q;
    logic [N-1:0]     w_dd_mag, w_dv_mag;
    logic [N-1:0]     w_q_res, w_r_res;

    div_step #(.N(N)) u_step (
        .i_r       (r_rem),
        .i_q       (r_q),
        .i_divisor (r_dvsr),
        .o_r       (w_step_r),
        .o_q       (w_step_q)
    );

`ifdef DIV_SIGNED_EN
    logic r_neg_q, w_neg_q_nxt;
    logic r_neg_r, w_neg_r_nxt;

    // Magnitude of -2^(N-1) wraps to itself, which reads correctly as unsigned.
    assign w_dd_mag = dividend[N-1] ? -dividend : dividend;
    assign w_dv_mag = divisor[N-1]  ? -divisor  : divisor;
    assign w_q_res  = r_neg_q ? -w_step_q : w_step_q;
    assign w_r_res  = r_neg_r ? -w_step_r : w_step_r;

    always_comb begin
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        if (r_state == IDLE && start) begin
            w_neg_q_nxt = dividend[N-1] ^ divisor[N-1];
            w_neg_r_nxt = dividend[N-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
        end
    end
`else
    assign w_dd_mag = dividend;
    assign w_dv_mag = divisor;
    assign w_q_res  = w_step_q;
    assign w_r_res  = w_step_r;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_q_nxt     = r_q;
        w_dvsr_nxt  = r_dvsr;
        w_quot_nxt  = r_quot;
        w_remo_nxt  = r_remo;
        w_busy_nxt  = r_busy;
        w_fin_nxt   = 1'b0;
        w_dbz_nxt   = r_dbz;
        case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_busy_nxt = 1'b1;
                    if (divisor == '0) begin
                        w_state_nxt = DONE;
                        w_fin_nxt   = 1'b1;
                        w_quot_nxt  = '1;
                        w_remo_nxt  = dividend;
                        w_dbz_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = CALC;
                        w_rem_nxt   = '0;
                        w_q_nxt     = w_dd_mag;
                        w_dvsr_nxt  = w_dv_mag;
                        w_cnt_nxt   = CNT_W'(N);
                    end
                end
            end
            CALC: begin
                w_rem_nxt = w_step_r;
                w_q_nxt   = w_step_q;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                    w_fin_nxt   = 1'b1;
                    w_quot_nxt  = w_q_res;
                    w_remo_nxt  = w_r_res;
                    w_dbz_nxt   = 1'b0;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_dvsr  <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_q     <= w_q_nxt;
            r_dvsr  <= w_dvsr_nxt;
            r_quot  <= w_quot_nxt;
            r_remo  <= w_remo_nxt;
            r_busy  <= w_busy_nxt;
            r_fin   <= w_fin_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign busy        = r_busy;
    assign finish      = r_fin;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider at N=8.
module tb_restoring_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         finish;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .finish      (finish),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Launch one op; lat = cycles after the accepting edge until finish, bz = busy cycles seen.
    task automatic run_op(input logic [N-1:0] dd, input logic [N-1:0] dv,
                          output int lat, output int bz);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        tick();
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h00;
        lat = 0;
        bz  = busy ? 1 : 0;
        while (!finish && lat < 40) begin
            tick();
            lat++;
            if (busy) bz++;
        end
    endtask

    initial begin : stim
        int lat, bz, fcnt, f1, f2;
        logic [N-1:0] q1, r1, q2, r2;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_quot", quotient, 0);
        check("rst_rem",  remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_fin",  finish, 0);
        check("rst_dbz",  div_by_zero, 0);

        // 100 / 7
        run_op(8'd100, 8'd7, lat, bz);
        check("u100_7_lat",  lat, 8);
        check("u100_7_busy", bz, 9);
        check("u100_7_q",    quotient, 14);
        check("u100_7_r",    remainder, 2);
        check("u100_7_dbz",  div_by_zero, 0);
        tick();
        check("u100_7_fin_drop",  finish, 0);
        check("u100_7_busy_drop", busy, 0);

        // 45 / 0
        run_op(8'd45, 8'd0, lat, bz);
        check("dz_lat", lat, 0);
        check("dz_q",   quotient, 255);
        check("dz_r",   remainder, 45);
        check("dz_dbz", div_by_zero, 1);
        tick();
        check("dz_fin_drop", finish, 0);

        // 9 / 3; results of the previous op must hold after start
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        tick();
        start = 1'b0;
        check("hold_q",   quotient, 255);
        check("hold_dbz", div_by_zero, 1);
        lat = 0;
        while (!finish && lat < 40) begin tick(); lat++; end
        check("u9_3_lat", lat, 8);
        check("u9_3_q",   quotient, 3);
        check("u9_3_r",   remainder, 0);
        check("u9_3_dbz", div_by_zero, 0);
        tick();

        run_op(8'd5, 8'd200, lat, bz);
        check("u5_200_q", quotient, 0);
        check("u5_200_r", remainder, 5);
        tick();

        run_op(8'd255, 8'd1, lat, bz);
`ifdef DIV_SIGNED_EN
        check("u255_1_q", quotient, 8'hFF);
`else
        check("u255_1_q", quotient, 255);
`endif
        check("u255_1_r", remainder, 0);
        tick();

        // Reset 4 cycles into 200/13: abort, no finish
        start = 1'b1; dividend = 8'd200; divisor = 8'd13;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_quot", quotient, 0);
        check("abort_rem",  remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_fin",  finish, 0);
        check("abort_dbz",  div_by_zero, 0);
        fcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (finish) fcnt++;
        end
        check("abort_no_finish", fcnt, 0);

        run_op(8'd200, 8'd13, lat, bz);
        check("u200_13_lat", lat, 8);
`ifdef DIV_SIGNED_EN
        check("s200_13_q", quotient, 8'hFC);
        check("s200_13_r", remainder, 8'hFC);
`else
        check("u200_13_q", quotient, 15);
        check("u200_13_r", remainder, 5);
`endif
        tick();

        // start held high; operands switched mid-CALC are ignored until the next accept
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        f1 = -1; f2 = -1; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 3) begin dividend = 8'd9; divisor = 8'd3; end
            if (finish) begin
                if (f1 < 0) begin f1 = c; q1 = quotient; r1 = remainder; end
                else if (f2 < 0) begin f2 = c; q2 = quotient; r2 = remainder; end
            end
        end
        start = 1'b0;
        check("b2b_first_at", f1, 9);
        check("b2b_spacing",  f2 - f1, 10);
        check("b2b_q1", q1, 14);
        check("b2b_r1", r1, 2);
        check("b2b_q2", q2, 3);
        check("b2b_r2", r2, 0);
        fcnt = 0;
        while (busy && fcnt < 30) begin tick(); fcnt++; end
        check("b2b_drain", busy, 0);
        tick();

`ifdef DIV_SIGNED_EN
        run_op(8'h9C, 8'd7, lat, bz);
        check("s_m100_7_lat", lat, 8);
        check("s_m100_7_q",   quotient, 8'hF2);
        check("s_m100_7_r",   remainder, 8'hFE);
        tick();
        run_op(8'h80, 8'hFF, lat, bz);
        check("s_ovf_q",   quotient, 8'h80);
        check("s_ovf_r",   remainder, 0);
        check("s_ovf_dbz", div_by_zero, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
